// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and the word size in bytes.
package cpu_types_pkg;
  localparam int WBYTES = 4;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Sequential next PC; wraps modulo 2^32 at the top of the address space.
  function automatic word_t next_pc(input word_t pc);
    return pc + word_t'(WBYTES);
  endfunction
endpackage

// File: rtl/ifid_latch.sv
// IF/ID pipeline register: load a new instruction, insert a bubble, or hold.
module ifid_latch
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  bubble,
  input  word_t next_instr,
  input  word_t next_npc,
  output word_t instr,
  output word_t npc,
  output logic  valid
);

  // Bubble has priority over load so a flush always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
      npc   <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= '0;
      npc   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= next_instr;
      npc   <= next_npc;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, one-entry skid buffer and fetch FSM feeding the IF/ID latch.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         ihit,
  input  word_t        imemload,
  output logic         iREN,
  output word_t        imemaddr,
  input  logic         ifid_en,
  input  logic         ifid_flush,
  input  logic         redirect,
  input  word_t        redirect_addr,
  input  logic         halt,
  output word_t        ifid_instr,
  output word_t        ifid_npc,
  output logic         ifid_valid,
  output fetch_state_t fsm_state
);

  // Handshake: ihit is a one-cycle valid from the icache with no back-pressure;
  // ifid_en is the downstream ready. A word arriving while ifid_en=0 is parked in
  // the skid buffer and fetching pauses (HOLD) until the latch accepts it.

  fetch_state_t state;
  word_t        pc;
  word_t        buf_instr;
  word_t        buf_npc;
  word_t        pc_plus4;

  logic  latch_load;
  logic  latch_bubble;
  word_t latch_instr;
  word_t latch_npc;

  assign pc_plus4  = next_pc(pc);
  assign imemaddr  = pc;
  assign iREN      = (state == FETCH);
  assign fsm_state = state;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= FETCH;
      pc        <= PC_INIT;
      buf_instr <= '0;
      buf_npc   <= '0;
    end else if (halt) begin
      state <= HALTED;
    end else if (state == HALTED) begin
      state <= HALTED;
    end else if (redirect) begin
      pc    <= {redirect_addr[31:2], 2'b00};
      state <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (ihit) begin
            pc <= pc_plus4;
            if (!ifid_en) begin
              buf_instr <= imemload;
              buf_npc   <= pc_plus4;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (ifid_en) state <= FETCH;
        end
        default: state <= state;
      endcase
    end
  end

  // Latch control: HALTED freezes outputs; halt/flush force a bubble; a stalled
  // latch holds; a redirect discards whatever would have been loaded.
  always_comb begin
    latch_load   = 1'b0;
    latch_bubble = 1'b0;
    latch_instr  = imemload;
    latch_npc    = pc_plus4;
    if (state == HALTED) begin
      latch_load = 1'b0;
    end else if (halt || ifid_flush) begin
      latch_bubble = 1'b1;
    end else if (!ifid_en) begin
      latch_load = 1'b0;
    end else if (redirect) begin
      latch_bubble = 1'b1;
    end else if (state == HOLD) begin
      latch_load  = 1'b1;
      latch_instr = buf_instr;
      latch_npc   = buf_npc;
    end else if (ihit) begin
      latch_load = 1'b1;
    end else begin
      latch_bubble = 1'b1;
    end
  end

  ifid_latch u_ifid (
    .clk        (CLK),
    .rst_n      (nRST),
    .load       (latch_load),
    .bubble     (latch_bubble),
    .next_instr (latch_instr),
    .next_npc   (latch_npc),
    .instr      (ifid_instr),
    .npc        (ifid_npc),
    .valid      (ifid_valid)
  );

endmodule
